// File: rtl/return_addr_stack.sv
// return_addr_stack
//   Return-address stack beside the PC register. A call pushes PC+1 from the
//   incrementer; a return pops it so the next-PC mux can redirect fetch
//   without a memory access.
//
// Parameters
//   WIDTH  address width (matches PC width)
//   DEPTH  number of entries, power of two, >= 2
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   reset      synchronous active-high reset
//   push       call: store push_data on this edge
//   pop        return: discard top entry on this edge
//   push_data  return address (PC+1)
//   clr_err    synchronous clear of the sticky error flags
//   top        current top-of-stack, 0 when empty (registered state only)
//   count      entries held, 0..DEPTH
//   empty      count == 0
//   full       count == DEPTH
//   overflow   sticky: a push was dropped while full
//   underflow  sticky: a pop was made while empty
//
// Configuration
//   RAS_WRAP_EN  when defined, push while full overwrites the oldest entry
//                circularly instead of being dropped; overflow never sets.
module return_addr_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    topIdx;

  // Decoded per-edge action
  logic             memWe;
  logic [PW-1:0]    memAddr;
  logic [PW-1:0]    wpNxt;
  logic [PW:0]      cntNxt;
  logic             ovfSet;
  logic             unfSet;

  // wp is modulo DEPTH, so wp-1 wraps naturally to the last slot.
  assign topIdx = wp - PTR_ONE;
  assign empty  = (count == '0);
  assign full   = (count == CNT_FULL);
  assign top    = empty ? '0 : mem[topIdx];

  always_comb begin
    memWe   = 1'b0;
    memAddr = wp;
    wpNxt   = wp;
    cntNxt  = count;
    ovfSet  = 1'b0;
    unfSet  = 1'b0;
    if (push && pop && !empty) begin
      // Tail call / simultaneous call+return: replace top in place.
      memWe   = 1'b1;
      memAddr = topIdx;
    end else if (push && !full) begin
      // Also covers push+pop on an empty stack (plain push, no underflow).
      memWe  = 1'b1;
      wpNxt  = wp + PTR_ONE;
      cntNxt = count + CNT_ONE;
    end else if (push) begin
`ifdef RAS_WRAP_EN
      // Circular overwrite: the slot at wp holds the oldest entry when full.
      memWe = 1'b1;
      wpNxt = wp + PTR_ONE;
`else
      ovfSet = 1'b1;
`endif
    end else if (pop && !empty) begin
      wpNxt  = topIdx;
      cntNxt = count - CNT_ONE;
    end else if (pop) begin
      unfSet = 1'b1;
    end
  end

  // Storage carries no reset; empty masks stale contents on top.
  always_ff @(posedge clk) begin
    if (memWe && !reset) mem[memAddr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wp        <= wpNxt;
      count     <= cntNxt;
      // A new error on the same edge as clr_err wins.
      overflow  <= ovfSet | (overflow  & ~clr_err);
      underflow <= unfSet | (underflow & ~clr_err);
    end
  end

endmodule

// File: tb/tb_return_addr_stack.sv
// tb_return_addr_stack
//   Directed vector table, hand sequences for fill/overflow/wrap, and a
//   randomized push/pop mix against a queue-based reference stack.
module tb_return_addr_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             reset, push, pop, clr_err;
  logic [WIDTH-1:0] push_data;
  logic [WIDTH-1:0] top;
  logic [4:0]       count;
  logic             empty, full, overflow, underflow;

  int errors = 0;
  int checks = 0;

  return_addr_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .push_data(push_data),
    .clr_err(clr_err), .top(top), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, psh, pp, clr;
    logic [15:0] d;
    logic [15:0] eTop;
    int          eCnt;
    logic        eOvf, eUnf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic psh, logic pp, logic clr, logic [15:0] d,
                              logic [15:0] eTop, int eCnt, logic eOvf, logic eUnf);
    vec_t v;
    v.rst = rst; v.psh = psh; v.pp = pp; v.clr = clr; v.d = d;
    v.eTop = eTop; v.eCnt = eCnt; v.eOvf = eOvf; v.eUnf = eUnf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic psh, input logic pp, input logic clr,
                      input logic [15:0] d);
    reset = rst; push = psh; pop = pp; clr_err = clr; push_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chkAll(input string nm, input logic [15:0] eTop, input int eCnt,
                        input logic eOvf, input logic eUnf);
    chk({nm, ".top"}, top, eTop);
    chk({nm, ".count"}, count, eCnt);
    chk({nm, ".empty"}, empty, eCnt == 0);
    chk({nm, ".full"}, full, eCnt == DEPTH);
    chk({nm, ".ovf"}, overflow, eOvf);
    chk({nm, ".unf"}, underflow, eUnf);
  endtask

  // Reference model for the random phase
  logic [15:0] mq[$];
  logic        mOvf, mUnf;

  initial begin
    logic [15:0] pc;
    logic        p, q, c;
    logic [15:0] expTop;
    int          bias;

    reset = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; push_data = '0;

    //          rst psh pp clr data      top      cnt ovf unf
    vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0011, 16'h0011, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0022, 16'h0022, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0033, 16'h0033, 3, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0022, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0011, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 16'h0000, 16'h0000, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0005, 16'h0005, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 16'h0077, 16'h0077, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 16'h0009, 16'h0009, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 16'h00A1, 16'h00A1, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 16'h00A2, 16'h00A2, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 16'h00A3, 16'h00A3, 4, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 16'hAAAA, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0042, 16'h0042, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 16'h0043, 16'h0000, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].psh, vecs[i].pp, vecs[i].clr, vecs[i].d);
      chkAll($sformatf("vec%0d", i), vecs[i].eTop, vecs[i].eCnt, vecs[i].eOvf, vecs[i].eUnf);
    end

    // Fill to DEPTH, then push while full
    step(1, 0, 0, 0, 16'h0);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 0, 0, 16'h1000 + 16'(i));
      chk($sformatf("fill%0d.top", i), top, 16'h1000 + 16'(i));
      chk($sformatf("fill%0d.count", i), count, i + 1);
    end
    chkAll("full", 16'h100F, DEPTH, 0, 0);
    step(0, 1, 0, 0, 16'hBEEF);
`ifdef RAS_WRAP_EN
    chkAll("pushFull", 16'hBEEF, DEPTH, 0, 0);
`else
    chkAll("pushFull", 16'h100F, DEPTH, 1, 0);
`endif
    for (int k = 0; k < DEPTH; k++) begin
`ifdef RAS_WRAP_EN
      expTop = (k == 0) ? 16'hBEEF : 16'h1010 - 16'(k);
`else
      expTop = 16'h100F - 16'(k);
`endif
      chk($sformatf("drain%0d.top", k), top, expTop);
      step(0, 0, 1, 0, 16'h0);
      chk($sformatf("drain%0d.count", k), count, DEPTH - 1 - k);
    end
`ifdef RAS_WRAP_EN
    chkAll("drained", 16'h0000, 0, 0, 0);
`else
    chkAll("drained", 16'h0000, 0, 1, 0);
    step(0, 0, 0, 1, 16'h0);
    chkAll("ovfClr", 16'h0000, 0, 0, 0);
`endif

    // Push+pop while full overwrites top in both builds
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, 16'h2000 + 16'(i));
    step(0, 1, 1, 0, 16'hCAFE);
    chkAll("pushPopFull", 16'hCAFE, DEPTH, 0, 0);
    step(0, 0, 1, 0, 16'h0);
    chkAll("pushPopFull.pop", 16'h200E, DEPTH - 1, 0, 0);
    // Overflow set then reset clears it
    step(0, 1, 0, 0, 16'h3000);
    step(0, 1, 0, 0, 16'h3001);
`ifdef RAS_WRAP_EN
    chkAll("ovfAgain", 16'h3001, DEPTH, 0, 0);
`else
    chkAll("ovfAgain", 16'h3000, DEPTH, 1, 0);
`endif
    step(1, 0, 0, 0, 16'h0);
    chkAll("rstFull", 16'h0000, 0, 0, 0);

    // Random mix against a reference stack; push_data is PC+1
    mq.delete(); mOvf = 0; mUnf = 0; pc = 16'h0100;
    for (int i = 0; i < 10000; i++) begin
      bias = ((i / 400) % 3);
      p = ($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5)));
      q = ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5)));
      c = ($urandom_range(0, 15) == 0);
      step(0, p, q, c, pc + 16'h1);
      if (c) begin mOvf = 0; mUnf = 0; end
      if (p && q && mq.size() > 0) mq[mq.size()-1] = pc + 16'h1;
      else if (p && mq.size() < DEPTH) mq.push_back(pc + 16'h1);
      else if (p) begin
`ifdef RAS_WRAP_EN
        void'(mq.pop_front());
        mq.push_back(pc + 16'h1);
`else
        mOvf = 1;
`endif
      end
      else if (q && mq.size() > 0) void'(mq.pop_back());
      else if (q) mUnf = 1;
      pc = q ? pc + 16'h3 : pc + 16'h1;
      expTop = (mq.size() > 0) ? mq[mq.size()-1] : 16'h0;
      chk($sformatf("rnd%0d.top", i), top, expTop);
      chk($sformatf("rnd%0d.count", i), count, mq.size());
      if (i % 16 == 0) begin
        chk($sformatf("rnd%0d.ovf", i), overflow, mOvf);
        chk($sformatf("rnd%0d.unf", i), underflow, mUnf);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/return_addr_stack.md
# return_addr_stack

Hardware return-address stack for the 16-bit datapath. On a call it pushes the incrementer's next-PC value (PC + 1). On a return it pops that value back, so the PC-select mux can redirect fetch without a memory access. It sits beside the PC register: the write side is fed by the PC+1 adder output, and the read side feeds the return input of the next-PC mux.

## Interface
Parameters:
- `WIDTH`, 16, address width; matches PC width.
- `DEPTH`, 16, number of entries; power of two, minimum 2.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  synchronous, active-high; one clock; the polarity and synchronicity are fixed.
- `push`  input  1  call: store `push_data` on this edge.
- `pop`  input  1  return: discard top entry on this edge.
- `push_data`  input  WIDTH  return address (PC+1 from the incrementer).
- `clr_err`  input  1  synchronous clear of the sticky error flags.
- `top`  output  WIDTH  current top-of-stack value; 0 when empty.
- `count`  output  log2(DEPTH)+1  entries held, 0..DEPTH.
- `empty`  output  1  `count == 0`.
- `full`  output  1  `count == DEPTH`.
- `overflow`  output  1  sticky: a push was dropped while full.
- `underflow`  output  1  sticky: a pop was made while empty.

## Operation
- Storage: register array `mem[0..DEPTH-1]`, write pointer `wp` (log2(DEPTH) bits, wraps modulo DEPTH), and occupancy `count`.
- `top` = `mem[wp-1]` (modulo DEPTH) when `count != 0`, else 0. It is combinational from registered state.
- Per-edge actions, evaluated in priority order:
  - `reset`: `wp=0`, `count=0`, `overflow=0`, `underflow=0`. The contents of `mem` are don't-care, but `top` reads 0 because the stack is empty.
  - `push & pop`, `count>0`: overwrite the top entry `mem[wp-1]` with `push_data`. `wp` and `count` are unchanged. This covers a tail call or simultaneous call/return.
  - `push & pop`, `count==0`: behaves as a plain push. `underflow` is not set.
  - `push` only, not full: `mem[wp]=push_data`, `wp+=1`, `count+=1`.
  - `push` only, full: behaviour depends on the configuration (see Configuration).
  - `pop` only, `count>0`: `wp-=1`, `count-=1`. `mem` is not modified.
  - `pop` only, empty: no state change, `underflow` is set to 1.
  - neither: hold.
- `clr_err` clears both sticky flags. If a new error occurs on the same edge as `clr_err`, the flag is set; the set wins.
- `count` never exceeds DEPTH and never goes below 0.

## Timing
- Single clock domain. No combinational path exists from `push`/`pop`/`push_data` to any output.
- Write latency is 1 cycle: when `push` is sampled at edge N, `top == push_data` is visible after edge N.
- Pop latency is 1 cycle: after the pop edge, `top` shows the previous entry, or 0 if the stack is now empty.
- Back-to-back push/pop on every cycle is supported with no bubbles.
- Reset values: `top=0`, `count=0`, `empty=1`, `full=0`, `overflow=0`, `underflow=0`.
- Reset asserted mid-sequence discards all entries on that edge, regardless of `push`/`pop`.

## Configuration
- Macro: `RAS_WRAP_EN`.
- When defined, push while full uses circular overwrite:
  - `mem[wp]=push_data`, `wp+=1`, and `count` stays at DEPTH.
  - The oldest entry is lost.
  - `overflow` is never set.
- When not defined, push while full is dropped:
  - `mem`, `wp` and `count` are unchanged.
  - `overflow` is set to 1.
- Push+pop while full is identical in both builds: the top entry is overwritten.

## Test plan
- Reset, then push 0x0011, 0x0022, 0x0033 on consecutive cycles -> `top` is 0x0011, 0x0022, 0x0033 after each edge; `count=3`; then 3 pops -> `top` is 0x0022, 0x0011, 0x0000, and `empty=1`.
- Pop while empty -> `underflow=1` and `count` stays 0. Then assert `clr_err` -> `underflow=0`. Then assert pop and `clr_err` together on an empty stack -> `underflow=1`.
- Push 0x1000..0x100F (16 values) -> `full=1`, `top=0x100F`; then push 0xBEEF:
  - without `RAS_WRAP_EN`: `overflow=1`, `top=0x100F`, and 16 pops return 0x100F..0x1000.
  - with `RAS_WRAP_EN`: `overflow=0`, `top=0xBEEF`, and 16 pops return 0xBEEF, 0x100F..0x1001.
- Push 0x0005, then push+pop with 0x0077 -> `count=1`, `top=0x0077`. Then push+pop on an empty stack with 0x0009 -> `count=1`, `top=0x0009`, `underflow=0`.
- Push 4 entries, then assert `reset` together with `push=1` for one cycle -> `count=0`, `top=0`, `empty=1`, and both flags are 0.
- Random push/pop mix for 10k cycles, compared against a reference model of the stack, with `push_data` driven from a PC counter through the incrementer -> `top` and `count` match every cycle.
